// File: rtl/alu_seq_pkg.sv
// Shared constants, FSM state type and writeback-class decode for the ALU sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int RIDX_W = 4;
  localparam int FLAG_W = 5;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_CMPX  = 4'b1010;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_RSHI  = 4'b1110;

  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_LSH  = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPND = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  // True when the encoding produces a register result and a flag update.
  function automatic logic is_wb_class(input logic [3:0] op, input logic [3:0] ext);
    logic wb;
    wb = 1'b0;
    case (op)
      OP_RTYPE: wb = ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'hD, 4'hE};
      OP_ADDI, OP_ADDUI, OP_ADDCI, OP_MOVI, OP_SHIFT, OP_RSHI: wb = 1'b1;
      OP_CMPX:  wb = ext inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6};
      default:  wb = 1'b0;
    endcase
    return wb;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU drive/capture, status and debug signals of the ALU sequencer.
interface alu_sequencer_if;
  import alu_seq_pkg::*;

  logic                inst_valid;
  logic                inst_ready;
  logic [DATA_W-1:0]   inst;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [3:0]          alu_opcode;
  logic [3:0]          alu_opext;
  logic [DATA_W-1:0]   alu_s;
  logic [FLAG_W-1:0]   alu_clfzn;
  logic [FLAG_W-1:0]   psr;
  logic                retire;
  logic [RIDX_W-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    output inst_valid, inst, alu_s, alu_clfzn, dbg_addr,
    input  inst_ready, alu_a, alu_b, alu_opcode, alu_opext, psr, retire, dbg_data
  );

  modport slave (
    input  inst_valid, inst, alu_s, alu_clfzn, dbg_addr,
    output inst_ready, alu_a, alu_b, alu_opcode, alu_opext, psr, retire, dbg_data
  );

endinterface

// File: rtl/alu_regfile.sv
// 16x16 register file: two operand read ports, a debug read port and one write port.
// ALU_SEQ_R0_ZERO_EN defined: R0 has no storage and always reads as zero.
module alu_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RIDX_W-1:0] ra_addr_i,
  input  logic [RIDX_W-1:0] rb_addr_i,
  input  logic [RIDX_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  output logic [DATA_W-1:0] dbg_data_o,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

`ifdef ALU_SEQ_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DATA_W-1:0] reg_val [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (R0_ZERO && gi == 0) begin : g_hard
      assign reg_val[gi] = '0;
    end else begin : g_ff
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (we_i && (wa_i == RIDX_W'(gi))) begin
          r_q <= wd_i;
        end
      end
      assign reg_val[gi] = r_q;
    end
  end

  assign ra_data_o  = reg_val[ra_addr_i];
  assign rb_data_o  = reg_val[rb_addr_i];
  assign dbg_data_o = reg_val[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Four-cycle issue/execute/writeback controller in front of the combinational 16-bit ALU.
// ALU_SEQ_R0_ZERO_EN (resolved inside alu_regfile) hardwires R0 to zero.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   inst_q;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [3:0]          alu_opcode_q, alu_opext_q;
  logic [DATA_W-1:0]   res_q;
  logic [FLAG_W-1:0]   flags_q, psr_q;

  logic                inst_ready, accept, wb_en;
  logic [3:0]          op, ext, rdest, rsrc;
  logic [7:0]          imm8;
  logic [DATA_W-1:0]   rd_data, rs_data, imm_sext, imm_zext;

  assign op       = inst_q[15:12];
  assign rdest    = inst_q[11:8];
  assign ext      = inst_q[7:4];
  assign rsrc     = inst_q[3:0];
  assign imm8     = inst_q[7:0];
  assign imm_sext = {{(DATA_W-8){imm8[7]}}, imm8};
  assign imm_zext = {{(DATA_W-8){1'b0}}, imm8};

  alu_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_addr_i  (rdest),
    .rb_addr_i  (rsrc),
    .dbg_addr_i (bus.dbg_addr),
    .ra_data_o  (rd_data),
    .rb_data_o  (rs_data),
    .dbg_data_o (bus.dbg_data),
    .we_i       (wb_en),
    .wa_i       (rdest),
    .wd_i       (res_q)
  );

  always_comb begin
    state_d    = state_q;
    inst_ready = 1'b0;
    wb_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        inst_ready = 1'b1;
        if (bus.inst_valid) state_d = OPND;
      end
      OPND: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        state_d = IDLE;
        wb_en   = is_wb_class(op, ext);
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = inst_ready & bus.inst_valid;

  // Operand routing; the I-type imm8 shares bits with opext, which is still forwarded as-is.
  always_comb begin
    alu_a_d = rd_data;
    alu_b_d = rs_data;
    case (op)
      OP_RTYPE: if (ext == EXT_MOV) alu_a_d = rs_data;
      OP_ADDI, OP_ADDCI: alu_b_d = imm_sext;
      OP_ADDUI: alu_b_d = imm_zext;
      OP_MOVI: begin
        alu_a_d = imm_sext;
        alu_b_d = imm_sext;
      end
      OP_SHIFT: if (ext != EXT_LSH) alu_b_d = '0;
      OP_RSHI: alu_b_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      inst_q       <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_opext_q  <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      psr_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) inst_q <= bus.inst;
      if (state_q == OPND) begin
        alu_a_q      <= alu_a_d;
        alu_b_q      <= alu_b_d;
        alu_opcode_q <= op;
        alu_opext_q  <= ext;
      end
      if (state_q == EXEC) begin
        res_q   <= bus.alu_s;
        flags_q <= bus.alu_clfzn;
      end
      if (wb_en) psr_q <= flags_q;
    end
  end

  assign bus.inst_ready = inst_ready;
  assign bus.retire     = (state_q == WB);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_opext  = alu_opext_q;
  assign bus.psr        = psr_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU (add family and moves).
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if ifc();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural ALU: adds set C, F (signed overflow), Z; moves pass B with clear flags.
  logic [16:0] alu_sum;
  logic        is_add, is_mov;
  always_comb begin
    alu_sum = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b};
    is_add  = (ifc.alu_opcode == 4'b0000 && ifc.alu_opext == 4'b0101) ||
              (ifc.alu_opcode inside {4'b0101, 4'b0110, 4'b0111});
    is_mov  = (ifc.alu_opcode == 4'b0000 && ifc.alu_opext == 4'b1101) ||
              (ifc.alu_opcode == 4'b1101);
    ifc.alu_s     = 16'h0000;
    ifc.alu_clfzn = 5'b00000;
    if (is_add) begin
      ifc.alu_s        = alu_sum[15:0];
      ifc.alu_clfzn[4] = alu_sum[16];
      ifc.alu_clfzn[2] = (ifc.alu_a[15] == ifc.alu_b[15]) && (alu_sum[15] != ifc.alu_a[15]);
      ifc.alu_clfzn[1] = (alu_sum[15:0] == 16'h0000);
    end else if (is_mov) begin
      ifc.alu_s = ifc.alu_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    ifc.dbg_addr = addr;
    #1;
    d = ifc.dbg_data;
    check(tag, 32'(d), 32'(exp));
  endtask

  // Per-issue observations.
  int          ret_idx, n_ret, ready_idx;
  logic [15:0] a_seen, b_seen, dbg_wb;
  bit          noise_en = 1'b0;

  // Offers one instruction, then follows it until inst_ready returns (bounded).
  // Index k means "#1 after edge k", edge 0 being the handshake.
  task automatic issue(input logic [15:0] ins);
    @(negedge clk);
    ifc.inst       = ins;
    ifc.inst_valid = 1'b1;
    @(posedge clk);
    #1;
    if (noise_en) ifc.inst = 16'hD533;
    else ifc.inst_valid = 1'b0;
    ret_idx = -1; n_ret = 0; ready_idx = -1;
    a_seen = 16'h0; b_seen = 16'h0; dbg_wb = 16'h0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) begin
        a_seen = ifc.alu_a;
        b_seen = ifc.alu_b;
      end
      if (ifc.retire) begin
        n_ret++;
        ret_idx = k;
        dbg_wb  = ifc.dbg_data;
        ifc.inst_valid = 1'b0;
      end
      if (ifc.inst_ready) begin
        ready_idx = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    ifc.inst_valid = 1'b0;
    if (ready_idx < 0) check("issue_timeout_ready", 32'(ifc.inst_ready), 32'd1);
  endtask

  initial begin
    ifc.inst_valid = 1'b0;
    ifc.inst       = 16'h0000;
    ifc.dbg_addr   = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  32'(ifc.inst_ready), 32'd1);
    check("rst_retire", 32'(ifc.retire),     32'd0);
    check("rst_psr",    32'(ifc.psr),        32'd0);
    check("rst_alu_a",  32'(ifc.alu_a),      32'd0);
    check("rst_alu_b",  32'(ifc.alu_b),      32'd0);
    check("rst_opcode", 32'(ifc.alu_opcode), 32'd0);
    check_reg("rst_r1", 4'd1, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // MOVI R1,0x7F
    issue(16'hD17F);
    check("movi_retire_idx", 32'(ret_idx),   32'd2);
    check("movi_retire_cnt", 32'(n_ret),     32'd1);
    check("movi_ready_idx",  32'(ready_idx), 32'd3);
    check("movi_alu_a",      32'(a_seen),    32'h007F);
    check("movi_alu_b",      32'(b_seen),    32'h007F);
    check_reg("movi_r1", 4'd1, 16'h007F);
    check("movi_psr", 32'(ifc.psr), 32'd0);

    // Build R2 = 0xFF01: 0xFFFF + 0xFF80 + 0xFF82
    issue(16'hD2FF);
    check_reg("movi_r2_ffff", 4'd2, 16'hFFFF);
    issue(16'h5280);
    check_reg("addi_r2_ff7f", 4'd2, 16'hFF7F);
    check("addi_psr_c", 32'(ifc.psr), 32'h10);
    issue(16'h5282);
    check_reg("addi_r2_ff01", 4'd2, 16'hFF01);

    // ADDUI R2,0xFF wraps to zero
    ifc.dbg_addr = 4'd2;
    issue(16'h62FF);
    check("addui_alu_a",  32'(a_seen), 32'hFF01);
    check("addui_alu_b",  32'(b_seen), 32'h00FF);
    check("addui_dbg_wb", 32'(dbg_wb), 32'hFF01);
    check_reg("addui_r2", 4'd2, 16'h0000);
    check("addui_psr", 32'(ifc.psr), 32'h12);

    // R1 = 0xFF80 doubled eight times -> 0x8000, plus 0xFFFF -> 0x7FFF
    issue(16'hD180);
    for (int i = 0; i < 8; i++) issue(16'h0151);
    check_reg("dbl_r1", 4'd1, 16'h8000);
    issue(16'hD3FF);
    issue(16'h0153);
    check_reg("add_r1_7fff", 4'd1, 16'h7FFF);
    issue(16'hD201);
    issue(16'h0152);
    check_reg("add_r1_ovf", 4'd1, 16'h8000);
    check("add_psr_ovf", 32'(ifc.psr), 32'h04);

    // NOP with a competing inst_valid held during the busy cycles
    noise_en = 1'b1;
    issue(16'h0000);
    noise_en = 1'b0;
    check("nop_retire_cnt", 32'(n_ret),     32'd1);
    check("nop_ready_idx",  32'(ready_idx), 32'd3);
    check("nop_psr",        32'(ifc.psr),   32'h04);
    check_reg("nop_r1", 4'd1, 16'h8000);
    check_reg("nop_r2", 4'd2, 16'h0001);
    check_reg("nop_r5", 4'd5, 16'h0000);
    @(posedge clk);
    #1;
    check("nop_no_relatch_ready", 32'(ifc.inst_ready), 32'd1);

    // Reset during EXEC of MOVI R3,5
    @(negedge clk);
    ifc.inst       = 16'hD305;
    ifc.inst_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.inst_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready",  32'(ifc.inst_ready), 32'd1);
    check("abort_psr",    32'(ifc.psr),        32'd0);
    check("abort_retire", 32'(ifc.retire),     32'd0);
    check_reg("abort_r3", 4'd3, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_ready", 32'(ifc.inst_ready), 32'd1);
    check_reg("abort_r3_after", 4'd3, 16'h0000);

    // MOVI R0,5
    issue(16'hD005);
`ifdef ALU_SEQ_R0_ZERO_EN
    check_reg("movi_r0", 4'd0, 16'h0000);
`else
    check_reg("movi_r0", 4'd0, 16'h0005);
`endif
    check("movi_r0_psr", 32'(ifc.psr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
